// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between a UART receiver and a CPU read port.
// Drops pushes when full (sticky Overflow) and raises a level interrupt at IRQ_LEVEL.
module uart_rx_fifo #(
    parameter int DEPTH     = 16,
    parameter int IRQ_LEVEL = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       DataReadFromLine,
    input  logic [7:0]                 RxByte,
    input  logic [1:0]                 UARTOp,
    output logic [31:0]                ReadData,
    output logic                       ReadValid,
    output logic                       Empty,
    output logic                       Full,
    output logic [$clog2(DEPTH):0]     Count,
    output logic                       Overflow,
    output logic                       RxIrq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   read_data_q, read_data_d;
    logic          read_valid_q, read_valid_d;
    logic          overflow_q, overflow_d;

    logic pop_req, clr_req, is_full, is_empty;
    logic do_push, do_pop, drop;

    assign pop_req  = (UARTOp == 2'b01);
    assign clr_req  = (UARTOp == 2'b11);
    assign is_full  = (count_q == CW'(DEPTH));
    assign is_empty = (count_q == '0);

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_pop  = pop_req && !is_empty;
    assign do_push = DataReadFromLine && (!is_full || do_pop);
    assign drop    = DataReadFromLine && !do_push;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        read_data_d  = read_data_q;
        read_valid_d = 1'b0;
        overflow_d   = overflow_q;

        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d     = rd_ptr_q + AW'(1);
            read_data_d  = {24'b0, mem_q[rd_ptr_q]};
            read_valid_d = 1'b1;
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_req) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    // Storage is not reset; pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= RxByte;
        end
    end

    assign ReadData  = read_data_q;
    assign ReadValid = read_valid_q;
    assign Count     = count_q;
    assign Empty     = is_empty;
    assign Full      = is_full;
    assign Overflow  = overflow_q;
    assign RxIrq     = (count_q >= CW'(IRQ_LEVEL));

endmodule
